// File: rtl/spike_keyword_trainer.sv
// spike_keyword_trainer
//   Training front end for the keyword-spotting accelerator. While the button
//   is held, spikes are ORed into per-channel time bins and stored. On release,
//   the utterance is resampled to a fixed WIN_BINS window. The window is then
//   streamed out over valid/ready. Accepted examples are counted, and
//   system_ready rises once NUM_EXAMPLES have been collected.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   spike_valid         : spike event this cycle
//   channel_id          : channel of the spike (ids >= NUM_CH ignored)
//   button_pressed      : debounced button level
//   retrain             : pulse, discard session and restart training
//   ex_valid/ex_ready   : output window handshake
//   ex_data             : resampled bin, bit c = channel c spiked
//   ex_bin_idx, ex_last : position of the bin in the window
//   led, training_progress : examples collected
//   rec_active          : recording in progress
//   overflow            : current/last utterance filled the capture memory
//   err_short           : one-cycle pulse, utterance too short
//   system_ready        : training set complete
module spike_keyword_trainer #(
    parameter int NUM_CH       = 16,
    parameter int CH_W         = 4,
    parameter int BIN_CYCLES   = 100,
    parameter int MAX_BINS     = 300,
    parameter int WIN_BINS     = 50,
    parameter int MIN_BINS     = 8,
    parameter int NUM_EXAMPLES = 15,
    parameter int LED_W        = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          spike_valid,
    input  logic [CH_W-1:0]               channel_id,
    input  logic                          button_pressed,
    input  logic                          retrain,
    output logic                          ex_valid,
    input  logic                          ex_ready,
    output logic [NUM_CH-1:0]             ex_data,
    output logic [$clog2(WIN_BINS)-1:0]   ex_bin_idx,
    output logic                          ex_last,
    output logic [LED_W-1:0]              led,
    output logic [LED_W-1:0]              training_progress,
    output logic                          rec_active,
    output logic                          overflow,
    output logic                          err_short,
    output logic                          system_ready
);

    localparam int BC_W  = $clog2(BIN_CYCLES + 1);
    localparam int LEN_W = $clog2(MAX_BINS + 1);
    localparam int AW    = $clog2(MAX_BINS);
    localparam int PW    = $clog2(MAX_BINS * WIN_BINS + 1);
    localparam int IDX_W = $clog2(WIN_BINS);

    typedef enum logic [2:0] {IDLE, ARMED, RECORD, EMIT, READY} state_t;

    state_t              state, state_n;
    logic                prev_btn;
    logic                low_seen;    // a press needs the button seen low after reset
    logic [BC_W-1:0]     bin_cnt;
    logic [LEN_W-1:0]    len;         // bins completed so far
    logic [LEN_W-1:0]    len_l;       // final utterance length L
    logic [NUM_CH-1:0]   cur_bin;
    logic [NUM_CH-1:0]   spike_bit;
    logic [NUM_CH-1:0]   cur_spk;
    logic [NUM_CH-1:0]   mem [MAX_BINS];
    logic [LED_W-1:0]    count;

    logic                btn_press, btn_rel, full, bin_end, do_retrain;
    logic                accept, last_acc, load;
    logic [LEN_W-1:0]    len_next;
    logic [IDX_W-1:0]    ld_idx;
    logic [PW-1:0]       prod;
    logic [AW-1:0]       src_addr;
    logic [LED_W-1:0]    count_inc;

    assign btn_press  = low_seen && !prev_btn && button_pressed;
    assign btn_rel    = prev_btn && !button_pressed;
    assign full       = (len == LEN_W'(MAX_BINS));
    assign bin_end    = (bin_cnt == BC_W'(BIN_CYCLES - 1));
    assign len_next   = full ? LEN_W'(MAX_BINS) : len + LEN_W'(1);
    assign do_retrain = retrain && (state != IDLE);
    assign accept     = ex_valid && ex_ready;
    assign last_acc   = accept && ex_last;
    assign count_inc  = count + LED_W'(1);

    // Spikes are dropped once the capture memory is full.
    always_comb begin
        spike_bit = '0;
        if (spike_valid && int'(channel_id) < NUM_CH && !full)
            spike_bit[channel_id] = 1'b1;
    end
    assign cur_spk = cur_bin | spike_bit;

    // Next beat to fetch: bin 0 on the first EMIT cycle, else the successor of
    // the beat being accepted. Product is kept at full width so i*L never wraps.
    assign ld_idx   = ex_valid ? ex_bin_idx + IDX_W'(1) : '0;
    assign prod     = PW'(ld_idx) * PW'(len_l);
    assign src_addr = AW'(prod / PW'(WIN_BINS));
    assign load     = (state == EMIT) && (!ex_valid || (accept && !ex_last));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, ARMED: if (btn_press) state_n = RECORD;
            RECORD:      if (btn_rel)
                             state_n = (len_next < LEN_W'(MIN_BINS)) ? ARMED : EMIT;
            EMIT:        if (last_acc)
                             state_n = (count_inc == LED_W'(NUM_EXAMPLES)) ? READY : ARMED;
            default:     state_n = state;
        endcase
        if (do_retrain) state_n = ARMED;
    end

    // Capture memory has no reset; only entries below L are ever read.
    always_ff @(posedge clk) begin
        if (!rst && !do_retrain && state == RECORD && !full && (btn_rel || bin_end))
            mem[len[AW-1:0]] <= cur_spk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_btn   <= 1'b0;
            low_seen   <= 1'b0;
            bin_cnt    <= '0;
            len        <= '0;
            len_l      <= '0;
            cur_bin    <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            err_short  <= 1'b0;
            ex_valid   <= 1'b0;
            ex_data    <= '0;
            ex_bin_idx <= '0;
            ex_last    <= 1'b0;
        end else begin
            prev_btn  <= button_pressed;
            if (!button_pressed) low_seen <= 1'b1;
            err_short <= 1'b0;
            if (do_retrain) begin
                count    <= '0;
                ex_valid <= 1'b0;
                ex_last  <= 1'b0;
            end else begin
                case (state)
                    IDLE, ARMED: if (btn_press) begin
                        if (state == IDLE) count <= '0;
                        bin_cnt  <= '0;
                        len      <= '0;
                        cur_bin  <= '0;
                        overflow <= 1'b0;
                    end
                    RECORD: begin
                        if (btn_rel) begin
                            len_l <= len_next;
                            if (len_next < LEN_W'(MIN_BINS)) err_short <= 1'b1;
                        end else if (!full) begin
                            if (bin_end) begin
                                cur_bin <= '0;
                                bin_cnt <= '0;
                                len     <= len + LEN_W'(1);
                                if (len + LEN_W'(1) == LEN_W'(MAX_BINS)) overflow <= 1'b1;
                            end else begin
                                cur_bin <= cur_spk;
                                bin_cnt <= bin_cnt + BC_W'(1);
                            end
                        end
                    end
                    EMIT: begin
                        if (load) begin
                            ex_valid   <= 1'b1;
                            ex_data    <= mem[src_addr];
                            ex_bin_idx <= ld_idx;
                            ex_last    <= (ld_idx == IDX_W'(WIN_BINS - 1));
                        end else if (last_acc) begin
                            ex_valid <= 1'b0;
                            ex_last  <= 1'b0;
                            count    <= count_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rec_active        = (state == RECORD);
    assign system_ready      = (state == READY);
    assign led               = count;
    assign training_progress = count;

endmodule
